sram_axi_bridge: RTL and testbench

- Converts the core's two SRAM-like request/response ports (instruction and data) into one AXI master.
- Sits directly downstream of the CPU top, between the core's SRAM-like ports and the SoC AXI interconnect.
- Lets instruction and data memory take variable latency. Each port signals accept with addr_ok and completion with data_ok.
- Supports single-beat transfers only, with at most one outstanding read and one outstanding write.

---
 rtl/sram_axi_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
// Bridges the core's SRAM-like instruction and data ports onto a single-beat AXI master.
// Optional macro BRIDGE_RAW_CHECK_EN holds back reads that hit the pending write's word.
module sram_axi_bridge #(
    parameter int unsigned ID_W    = 4,
    parameter int unsigned INST_ID = 0,
    parameter int unsigned DATA_ID = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            inst_req,
    input  logic [1:0]      inst_size,
    input  logic [31:0]     inst_addr,
    output logic            inst_addr_ok,
    output logic            inst_data_ok,
    output logic [31:0]     inst_rdata,
    input  logic            data_req,
    input  logic            data_wr,
    input  logic [1:0]      data_size,
    input  logic [31:0]     data_addr,
    input  logic [3:0]      data_wstrb,
    input  logic [31:0]     data_wdata,
    output logic            data_addr_ok,
    output logic            data_data_ok,
    output logic [31:0]     data_rdata,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [2:0]      arsize,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic            rvalid,
    output logic            rready,
    output logic [31:0]     awaddr,
    output logic [2:0]      awsize,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wvalid,
    input  logic            wready,
    input  logic            bvalid,
    output logic            bready
);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_R    = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_REQ  = 2'd1;
    localparam logic [1:0] W_B    = 2'd2;

    localparam logic [ID_W-1:0] INST_ARID = ID_W'(INST_ID);
    localparam logic [ID_W-1:0] DATA_ARID = ID_W'(DATA_ID);

    logic [1:0] r_state, r_next;
    logic [1:0] w_state, w_next;
    logic       data_rd_req;
    logic       inst_accept, data_rd_accept, data_wr_accept;
    logic       raw_inst, raw_data;
    logic       rd_inst_done, rd_data_done, wr_done;
    logic       aw_fire, w_fire, aw_done, w_done, aw_ok, w_ok;

`ifdef BRIDGE_RAW_CHECK_EN
    // A read to the word still being written waits until the write has fully retired
    assign raw_inst = (w_state != W_IDLE) && (awaddr[31:2] == inst_addr[31:2]);
    assign raw_data = (w_state != W_IDLE) && (awaddr[31:2] == data_addr[31:2]);
`else
    assign raw_inst = 1'b0;
    assign raw_data = 1'b0;
`endif

    assign data_rd_req  = data_req && !data_wr;
    assign rd_inst_done = (r_state == R_R) && rvalid && (rid == INST_ARID);
    assign rd_data_done = (r_state == R_R) && rvalid && (rid == DATA_ARID);
    // A data read return takes the data_ok slot; the B response waits a cycle
    assign wr_done      = (w_state == W_B) && bvalid && !rd_data_done;
    assign bready       = (w_state == W_B) && !rd_data_done;

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign aw_ok   = aw_done || aw_fire;
    assign w_ok    = w_done || w_fire;

    assign inst_addr_ok = inst_accept;
    assign data_addr_ok = data_rd_accept || data_wr_accept;
    assign inst_data_ok = rd_inst_done;
    assign data_data_ok = rd_data_done || wr_done;
    assign inst_rdata   = rd_inst_done ? rdata : '0;
    assign data_rdata   = rd_data_done ? rdata : '0;

    // Read FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // Read FSM next state and arbitration (data read beats instruction fetch)
    always_comb begin
        r_next         = r_state;
        data_rd_accept = 1'b0;
        inst_accept    = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (data_rd_req) begin
                    data_rd_accept = resetn && !raw_data;
                end else begin
                    inst_accept = resetn && inst_req && !raw_inst;
                end
                if (data_rd_accept || inst_accept) begin
                    r_next = R_AR;
                end
            end
            R_AR: begin
                if (arready) begin
                    r_next = R_R;
                end
            end
            R_R: begin
                if (rvalid) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // AR channel registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            araddr  <= '0;
            arsize  <= '0;
            arid    <= '0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
        end else begin
            if (data_rd_accept) begin
                araddr <= data_addr;
                arsize <= {1'b0, data_size};
                arid   <= DATA_ARID;
            end else if (inst_accept) begin
                araddr <= inst_addr;
                arsize <= {1'b0, inst_size};
                arid   <= INST_ARID;
            end
            arvalid <= (r_next == R_AR);
            rready  <= (r_next == R_R);
        end
    end

    // Write FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Write FSM next state
    always_comb begin
        w_next         = w_state;
        data_wr_accept = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (resetn && data_req && data_wr) begin
                    data_wr_accept = 1'b1;
                    w_next         = W_REQ;
                end
            end
            W_REQ: begin
                if (aw_ok && w_ok) begin
                    w_next = W_B;
                end
            end
            W_B: begin
                if (wr_done) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // AW/W channel registers; each valid retires on its own handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            awaddr  <= '0;
            awsize  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (data_wr_accept) begin
            awaddr  <= data_addr;
            awsize  <= {1'b0, data_size};
            wdata   <= data_wdata;
            wstrb   <= data_wstrb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_fire) begin
                awvalid <= 1'b0;
                aw_done <= 1'b1;
            end
            if (w_fire) begin
                wvalid <= 1'b0;
                w_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed table-driven bench for sram_axi_bridge, plus hand-written reset and write-payload sequences.
module tb_sram_axi_bridge;

    localparam int unsigned E_IAOK = 256;
    localparam int unsigned E_DAOK = 128;
    localparam int unsigned E_IDOK = 64;
    localparam int unsigned E_DDOK = 32;
    localparam int unsigned E_ARV  = 16;
    localparam int unsigned E_RR   = 8;
    localparam int unsigned E_AWV  = 4;
    localparam int unsigned E_WV   = 2;
    localparam int unsigned E_BR   = 1;

    typedef struct packed {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [31:0] daddr;
        logic        arr;
        logic        rv;
        logic [3:0]  rid_v;
        logic [31:0] rd;
        logic        awr;
        logic        wr;
        logic        bv;
        logic [8:0]  exp;
        logic [31:0] exp_ird;
        logic [31:0] exp_drd;
        logic [3:0]  exp_arid;
        logic [31:0] exp_araddr;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int tests;
    int failed;
    vec_t tbl[$];

    sram_axi_bridge #(.ID_W(4), .INST_ID(0), .DATA_ID(1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
                    arvalid, rready, awvalid, wvalid, bready});
    endfunction

    function automatic vec_t mk(
        input logic [31:0] ireq, input logic [31:0] iaddr,
        input logic [31:0] dreq, input logic [31:0] dwr, input logic [31:0] daddr,
        input logic [31:0] arr, input logic [31:0] rv, input logic [31:0] rid_v, input logic [31:0] rd,
        input logic [31:0] awr, input logic [31:0] wr, input logic [31:0] bv,
        input logic [31:0] e, input logic [31:0] eird, input logic [31:0] edrd,
        input logic [31:0] earid, input logic [31:0] earaddr);
        vec_t v;
        v.ireq = ireq[0];   v.iaddr = iaddr;
        v.dreq = dreq[0];   v.dwr = dwr[0];   v.daddr = daddr;
        v.arr = arr[0];     v.rv = rv[0];     v.rid_v = rid_v[3:0]; v.rd = rd;
        v.awr = awr[0];     v.wr = wr[0];     v.bv = bv[0];
        v.exp = e[8:0];     v.exp_ird = eird; v.exp_drd = edrd;
        v.exp_arid = earid[3:0]; v.exp_araddr = earaddr;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        inst_req = v.ireq;  inst_addr = v.iaddr;
        data_req = v.dreq;  data_wr = v.dwr;  data_addr = v.daddr;
        arready = v.arr;    rvalid = v.rv;    rid = v.rid_v;  rdata = v.rd;
        awready = v.awr;    wready = v.wr;    bvalid = v.bv;
        #1;
        chk($sformatf("vec%0d handshakes", idx), flags(), 32'(v.exp));
        chk($sformatf("vec%0d inst_rdata", idx), inst_rdata, v.exp_ird);
        chk($sformatf("vec%0d data_rdata", idx), data_rdata, v.exp_drd);
        if (v.exp[4]) begin
            chk($sformatf("vec%0d arid", idx), 32'(arid), 32'(v.exp_arid));
            chk($sformatf("vec%0d araddr", idx), araddr, v.exp_araddr);
            chk($sformatf("vec%0d arsize", idx), 32'(arsize), 32'd2);
        end
    endtask

    task automatic idle_inputs();
        inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0; data_addr = '0;
        arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    initial begin
        tests = 0;
        failed = 0;
        resetn = 1'b0;
        inst_size = 2'd2;
        data_size = 2'd2;
        data_wstrb = 4'hF;
        data_wdata = 32'h1234ABCD;
        idle_inputs();

        // Single instruction read, arready at 2, rvalid at 4
        tbl.push_back(mk(1, 32'h1C000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IAOK, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_ARV, 0, 0, 0, 32'h1C000000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_ARV, 0, 0, 0, 32'h1C000000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RR, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h02800C0C, 0, 0, 0, E_RR | E_IDOK, 32'h02800C0C, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Data read wins arbitration; held inst request taken afterwards
        tbl.push_back(mk(1, 32'h100, 1, 0, 32'h200, 0, 0, 0, 0, 0, 0, 0, E_DAOK, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h100, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_ARV, 0, 0, 1, 32'h200));
        tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0, E_RR | E_DDOK, 0, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IAOK, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_ARV, 0, 0, 0, 32'h100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h11112222, 0, 0, 0, E_RR | E_IDOK, 32'h11112222, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Write with wready at 1, awready at 3, bvalid at 5
        tbl.push_back(mk(0, 0, 1, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, E_DAOK, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_AWV | E_WV, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_AWV, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_AWV, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_BR, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_BR | E_DDOK, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Data read return collides with B response
        tbl.push_back(mk(0, 0, 1, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0, E_DAOK, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h400, 0, 0, 0, 0, 1, 1, 0, E_DAOK | E_AWV | E_WV, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_ARV | E_BR, 0, 0, 1, 32'h400));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'hCAFEF00D, 0, 0, 1, E_RR | E_DDOK, 0, 32'hCAFEF00D, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_BR | E_DDOK, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Instruction read concurrent with data write
        tbl.push_back(mk(1, 32'h500, 1, 1, 32'h600, 0, 0, 0, 0, 0, 0, 0, E_IAOK | E_DAOK, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, E_ARV | E_AWV | E_WV, 0, 0, 0, 32'h500));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h5A5A5A5A, 0, 0, 1, E_RR | E_BR | E_IDOK | E_DDOK, 32'h5A5A5A5A, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Read-after-write: 0x84 never blocked, 0x80 blocked only with the check enabled
        tbl.push_back(mk(0, 0, 1, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, E_DAOK, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h84, 0, 0, 0, 0, 1, 1, 0, E_DAOK | E_AWV | E_WV, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_ARV | E_BR, 0, 0, 1, 32'h84));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h84848484, 0, 0, 0, E_RR | E_DDOK, 0, 32'h84848484, 0, 0));
`ifdef BRIDGE_RAW_CHECK_EN
        tbl.push_back(mk(0, 0, 1, 0, 32'h80, 0, 0, 0, 0, 0, 0, 0, E_BR, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h80, 0, 0, 0, 0, 0, 0, 1, E_BR | E_DDOK, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h80, 0, 0, 0, 0, 0, 0, 0, E_DAOK, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_ARV, 0, 0, 1, 32'h80));
`else
        tbl.push_back(mk(0, 0, 1, 0, 32'h80, 0, 0, 0, 0, 0, 0, 0, E_BR | E_DAOK, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, E_ARV | E_BR | E_DDOK, 0, 0, 1, 32'h80));
`endif
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h80808080, 0, 0, 0, E_RR | E_DDOK, 0, 32'h80808080, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state, with requests asserted to show addr_ok stays low
        inst_req = 1'b1;
        data_req = 1'b1;
        #12;
        chk("reset handshakes", flags(), 32'd0);
        chk("reset araddr", araddr, 32'd0);
        chk("reset awaddr", awaddr, 32'd0);
        chk("reset wdata", wdata, 32'd0);
        chk("reset arid", 32'(arid), 32'd0);
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], i);
        end

        // Write payload latch: size 1, strobe 0x3, both channels handshake together
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h1F0;
        data_size = 2'd1; data_wstrb = 4'h3; data_wdata = 32'h0000A5A5;
        #1 chk("wr accept", 32'(data_addr_ok), 32'd1);
        @(negedge clk);
        data_req = 1'b0; data_wdata = 32'hFFFFFFFF; data_wstrb = 4'hF;
        awready = 1'b1; wready = 1'b1;
        #1;
        chk("wr handshakes", flags(), 32'(E_AWV | E_WV));
        chk("wr awaddr", awaddr, 32'h1F0);
        chk("wr awsize", 32'(awsize), 32'd1);
        chk("wr wdata", wdata, 32'h0000A5A5);
        chk("wr wstrb", 32'(wstrb), 32'h3);
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        #1 chk("wr bresp", flags(), 32'(E_BR | E_DDOK));
        @(negedge clk);
        bvalid = 1'b0; data_size = 2'd2;
        #1 chk("wr idle", flags(), 32'd0);

        // Reset asserted while the read sits in R_AR
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'h1C000008;
        #1 chk("rst_ar accept", 32'(inst_addr_ok), 32'd1);
        @(negedge clk);
        inst_req = 1'b0;
        #1 chk("rst_ar arvalid", 32'(arvalid), 32'd1);
        #2;
        resetn = 1'b0;
        inst_req = 1'b1; data_req = 1'b1; rvalid = 1'b1; bvalid = 1'b1;
        #1;
        chk("rst_ar handshakes", flags(), 32'd0);
        chk("rst_ar araddr", araddr, 32'd0);
        @(negedge clk);
        #1 chk("rst_ar held", flags(), 32'd0);
        idle_inputs();
        resetn = 1'b1;
        run_vec(mk(1, 32'h1C000010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IAOK, 0, 0, 0, 0), 100);
        run_vec(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_ARV, 0, 0, 0, 32'h1C000010), 101);
        run_vec(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h0BADF00D, 0, 0, 0, E_RR | E_IDOK, 32'h0BADF00D, 0, 0, 0), 102);
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 103);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
